uart_rx_fsm: RTL
================

Name: uart_rx_fsm

Overview:
UART receive controller. It is the counterpart of the UART TX FSM and sits at the RX pin of the UART block. It oversamples RX_IN by Prescale, detects the start bit, takes a majority-vote sample of each bit, deserializes LSB-first, and checks parity and stop bit. A received byte is delivered to the system side as P_DATA with a single-cycle Data_Valid pulse.

Parameters:
DATA_WIDTH, 8, number of data bits per frame.
PRESCALE_W, 6, width of the Prescale input. Legal Prescale values are 8, 16 and 32.

Ports:
CLK  in  1  system clock; all logic is on the rising edge.
RST  in  1  reset, synchronous, active-high.
RX_IN  in  1  serial line; idle level is 1.
PAR_EN  in  1  1 means the frame carries a parity bit.
PAR_TYP  in  1  0 = even parity, 1 = odd parity.
Prescale  in  PRESCALE_W  oversampling ratio, in clocks per bit.
P_DATA  out  DATA_WIDTH  received data word; holds its value until the next good frame.
Data_Valid  out  1  one-cycle pulse: P_DATA has just been updated.
Parity_Error  out  1  one-cycle pulse: a parity mismatch occurred.
Stop_Error  out  1  one-cycle pulse: the stop bit was sampled as 0.
busy  out  1  high while a frame is being received (registered).

Behaviour:
- Reset (RST=1 at a clock edge): state=IDLE, all counters=0, P_DATA=0, Data_Valid=0, Parity_Error=0, Stop_Error=0, busy=0. A reset mid-frame abandons the frame with no pulses.
- Gray-coded states: IDLE=000, START=001, DATA=011, PARITY=010, STOP=110.
- edge_cnt runs 0..Prescale-1 within each bit, then wraps to 0. bit_cnt counts data bits 0..DATA_WIDTH-1.
- Prescale, PAR_EN and PAR_TYP are captured when the start bit is detected. Changes during a frame have no effect.
- IDLE → START when RX_IN=0. That detection cycle is edge 0 of the start bit.
- Sampling: 3 samples are taken at edges P/2-1, P/2 and P/2+1; the bit value is the majority of the three. The decision is available at edge P/2+2.
- START: if the start sample is 1 (glitch), return to IDLE at the decision edge, with no error and busy cleared. Otherwise, at edge P-1 go to DATA.
- DATA: each majority bit is shifted in LSB-first. At edge P-1 of bit DATA_WIDTH-1, go to PARITY if PAR_EN=1, else to STOP.
- PARITY: the expected bit is XOR(data) for even parity, or its inverse for odd. A mismatch latches a pending parity error. At edge P-1 go to STOP.
- STOP: at edge P-1, for a 1-cycle pulse in the following cycle:
  - stop sample 0: Stop_Error=1;
  - pending parity error: Parity_Error=1;
  - neither error: P_DATA←shift register and Data_Valid=1.
  - In all cases go to IDLE.
- Both errors can pulse in the same cycle. Data_Valid never coincides with either error pulse.
- Back-to-back frames: IDLE can detect a new start bit in the same cycle the pulses are asserted.
- busy is registered: it rises 1 cycle after start detection and falls 1 cycle after the state leaves START/DATA/PARITY/STOP.
- Latency: Data_Valid is asserted at cycle (DATA_WIDTH+2+PAR_EN)·P, counted from the start-detect cycle (cycle 0).
- Illegal Prescale values (not 8/16/32): behaviour is unspecified, but the FSM must never lock up; the default branch returns to IDLE.

Optional Feature:
- RX_SYNC_EN defined: RX_IN passes through a 2-flop synchronizer, reset to 1. All detection and sampling use the synchronized signal, so every latency is 2 cycles longer.
- RX_SYNC_EN undefined: RX_IN is used directly and must already be synchronous to CLK.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings (shared with the TX FSM);
  - constants PAR_EVEN=0 and PAR_ODD=1;
  - the legal Prescale constants 8/16/32.
- Sub-module uart_rx_sampler holds edge_cnt, the 3-sample register and the majority vote. Outputs: edge_last (edge P-1) and bit_val/bit_rdy (valid at edge P/2+2).

Test Plan:
- P=8, PAR_EN=0, frame 0xA5 (stop=1) → P_DATA=0xA5; Data_Valid high for one cycle at cycle 80; no error pulses.
- P=16, PAR_EN=1, PAR_TYP=0, data 0x3C with correct parity bit 0 → P_DATA=0x3C, Data_Valid at cycle 176. Repeat with the parity bit flipped to 1 → Parity_Error pulse only; P_DATA keeps its previous value.
- P=8, stop bit driven 0 on data 0x55 → Stop_Error pulse at cycle 80, no Data_Valid. The line then returns to 1 with no spurious start detected.
- P=8, 2-cycle low glitch on RX_IN → back to IDLE by cycle 6, no pulses, busy low again by cycle 7.
- P=32, two back-to-back frames 0x01 then 0xFE (new start bit immediately after the stop bit) → two Data_Valid pulses 320 cycles apart with the correct data. Asserting RST in the middle of the second frame → all outputs 0 on the next cycle and no pulse.
- With RX_SYNC_EN defined, rerun test 1 → Data_Valid at cycle 82.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings (common with the TX FSM),
// parity type constants, legal oversampling ratios and the majority vote.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'b000;
  localparam logic [2:0] ST_START  = 3'b001;
  localparam logic [2:0] ST_DATA   = 3'b011;
  localparam logic [2:0] ST_PARITY = 3'b010;
  localparam logic [2:0] ST_STOP   = 3'b110;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Serial-line, configuration and delivery signals of the UART receiver.
// The master side drives the line and configuration, the slave is the receiver.
interface uart_rx_fsm_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
);

  logic                  RX_IN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [PRESCALE_W-1:0] Prescale;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  Parity_Error;
  logic                  Stop_Error;
  logic                  busy;

  modport master (
    output RX_IN, PAR_EN, PAR_TYP, Prescale,
    input  P_DATA, Data_Valid, Parity_Error, Stop_Error, busy
  );

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP, Prescale,
    output P_DATA, Data_Valid, Parity_Error, Stop_Error, busy
  );

endinterface

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling counter with a 3-sample majority vote taken around
// the bit centre (edges P/2-1, P/2, P/2+1); the decision is ready at edge P/2+2.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  run,
  input  logic                  rx,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  edge_last,
  output logic                  bit_val,
  output logic                  bit_rdy
);

  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] TWO = PRESCALE_W'(2);

  logic [PRESCALE_W-1:0] edge_cnt;
  logic [PRESCALE_W-1:0] half;
  logic [2:0]            samples;
  logic                  in_window;

  assign half      = prescale >> 1;
  assign edge_last = (edge_cnt == prescale - ONE);
  assign in_window = (edge_cnt == half - ONE) || (edge_cnt == half) ||
                     (edge_cnt == half + ONE);
  assign bit_rdy   = run && (edge_cnt == half + TWO);
  assign bit_val   = maj3(samples);

  // Samples are kept until the next window, so the vote stays valid up to edge P-1
  always_ff @(posedge CLK) begin
    if (RST) begin
      edge_cnt <= '0;
      samples  <= 3'b111;
    end else begin
      if (!run || edge_last) edge_cnt <= '0;
      else                   edge_cnt <= edge_cnt + ONE;
      if (run && in_window) samples <= {samples[1:0], rx};
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive controller: start detection, majority-voted LSB-first
// deserialisation, parity/stop checking. Define RX_SYNC_EN to add a 2-flop RX_IN synchronizer.
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input logic CLK,
  input logic RST,
  uart_rx_fsm_if.slave bus
);

  localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);

  logic rx_s;

`ifdef RX_SYNC_EN
  logic rx_meta;
  logic rx_sync;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= bus.RX_IN;
      rx_sync <= rx_meta;
    end
  end

  assign rx_s = rx_sync;
`else
  assign rx_s = bus.RX_IN;
`endif

  logic [2:0]            state;
  logic [2:0]            state_next;
  logic [PRESCALE_W-1:0] prescale_q;
  logic [PRESCALE_W-1:0] prescale_eff;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  par_err_q;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  start_det;
  logic                  run;
  logic                  edge_last;
  logic                  bit_val;
  logic                  bit_rdy;
  logic                  last_bit;
  logic                  par_exp;

  assign start_det    = (state == ST_IDLE) && !rx_s;
  assign run          = (state != ST_IDLE) || start_det;
  // The captured ratio is not loaded yet in the start-detect cycle
  assign prescale_eff = (state == ST_IDLE) ? bus.Prescale : prescale_q;
  assign last_bit     = (bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1));
  assign par_exp      = (par_typ_q == PAR_ODD) ? ~(^shift_reg) : ^shift_reg;

  uart_rx_sampler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_sampler (
    .CLK      (CLK),
    .RST      (RST),
    .run      (run),
    .rx       (rx_s),
    .prescale (prescale_eff),
    .edge_last(edge_last),
    .bit_val  (bit_val),
    .bit_rdy  (bit_rdy)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start_det) state_next = ST_START;
      ST_START: begin
        if (bit_rdy && bit_val) state_next = ST_IDLE;
        else if (edge_last)     state_next = ST_DATA;
      end
      ST_DATA:   if (edge_last && last_bit) state_next = par_en_q ? ST_PARITY : ST_STOP;
      ST_PARITY: if (edge_last) state_next = ST_STOP;
      ST_STOP:   if (edge_last) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state            <= ST_IDLE;
      prescale_q       <= '0;
      par_en_q         <= 1'b0;
      par_typ_q        <= 1'b0;
      par_err_q        <= 1'b0;
      shift_reg        <= '0;
      bit_cnt          <= '0;
      bus.P_DATA       <= '0;
      bus.Data_Valid   <= 1'b0;
      bus.Parity_Error <= 1'b0;
      bus.Stop_Error   <= 1'b0;
      bus.busy         <= 1'b0;
    end else begin
      state            <= state_next;
      bus.busy         <= (state_next != ST_IDLE);
      bus.Data_Valid   <= 1'b0;
      bus.Parity_Error <= 1'b0;
      bus.Stop_Error   <= 1'b0;
      if (start_det) begin
        prescale_q <= bus.Prescale;
        par_en_q   <= bus.PAR_EN;
        par_typ_q  <= bus.PAR_TYP;
        par_err_q  <= 1'b0;
        bit_cnt    <= '0;
      end
      if (state == ST_DATA) begin
        if (bit_rdy)   shift_reg <= {bit_val, shift_reg[DATA_WIDTH-1:1]};
        if (edge_last) bit_cnt   <= last_bit ? '0 : bit_cnt + 1'b1;
      end
      if (state == ST_PARITY && bit_rdy) par_err_q <= (bit_val != par_exp);
      // Errors and delivery are mutually exclusive; both errors may pulse together
      if (state == ST_STOP && edge_last) begin
        bus.Stop_Error   <= !bit_val;
        bus.Parity_Error <= par_err_q;
        if (bit_val && !par_err_q) begin
          bus.P_DATA     <= shift_reg;
          bus.Data_Valid <= 1'b1;
        end
      end
    end
  end

endmodule
